// File: rtl/cart_hdr_loader.sv
// Boot-time cartridge header loader: scans ROM bytes 0x0134..0x014D, checks the
// header checksum and latches type/size codes while holding the system in reset.
module cart_hdr_loader #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reload,
  input  logic [7:0]  rdata,
  output logic [14:0] oadr,
  output logic        ocs_rom,
  output logic        busy,
  output logic        sys_hold,
  output logic        valid,
  output logic [7:0]  mbc_type,
  output logic [2:0]  rom_size,
  output logic [1:0]  ram_size,
  output logic        size_err,
  output logic        hdr_ok
);

  localparam int unsigned AW = 15;
  localparam int unsigned CW = 4;
  localparam logic [AW-1:0] ADR_FIRST = AW'(16'h0134);
  localparam logic [AW-1:0] ADR_TYPE  = AW'(16'h0147);
  localparam logic [AW-1:0] ADR_ROM   = AW'(16'h0148);
  localparam logic [AW-1:0] ADR_RAM   = AW'(16'h0149);
  localparam logic [AW-1:0] ADR_CHK   = AW'(16'h014D);
  // The ADDR cycle is the first chip-select cycle, so WAIT only covers the rest.
  localparam logic [CW-1:0] WAIT_LAST = CW'((WAIT_CYCLES > 1) ? WAIT_CYCLES - 2 : 0);

  localparam logic [2:0] S_ADDR   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_SAMPLE = 3'd2;
  localparam logic [2:0] S_GAP    = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]    state;
  logic [2:0]    state_nx;
  logic [AW-1:0] addr;
  logic [7:0]    chk;
  logic [CW-1:0] wcnt;
  logic          capture_c;
  logic          cs_state_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_ADDR;
    else        state <= state_nx;
  end

  // Next state and the capture strobe that marks the rdata sampling edge.
  always_comb begin
    state_nx  = state;
    capture_c = 1'b0;
    case (state)
      S_ADDR: begin
        if (WAIT_CYCLES == 0) begin
          capture_c = 1'b1;
          state_nx  = S_GAP;
        end else if (WAIT_CYCLES == 1) begin
          state_nx = S_SAMPLE;
        end else begin
          state_nx = S_WAIT;
        end
      end
      S_WAIT:   if (wcnt == WAIT_LAST) state_nx = S_SAMPLE;
      S_SAMPLE: begin
        capture_c = 1'b1;
        state_nx  = S_GAP;
      end
      S_GAP:    state_nx = (addr == ADR_CHK) ? S_DONE : S_ADDR;
      S_DONE:   if (reload) state_nx = S_ADDR;
      default:  state_nx = S_ADDR;
    endcase
  end

  // Reset gates the select so the bus is released the moment reset asserts.
  assign cs_state_c = (state == S_ADDR) || (state == S_WAIT) || (state == S_SAMPLE);
  assign ocs_rom    = cs_state_c & reset;
  assign oadr       = cs_state_c ? addr : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr     <= ADR_FIRST;
      chk      <= '0;
      wcnt     <= '0;
      busy     <= 1'b1;
      sys_hold <= 1'b1;
      valid    <= 1'b0;
      mbc_type <= '0;
      rom_size <= '0;
      ram_size <= '0;
      size_err <= 1'b0;
      hdr_ok   <= 1'b0;
    end else begin
      if (state == S_ADDR)      wcnt <= '0;
      else if (state == S_WAIT) wcnt <= wcnt + CW'(1);

      if (state == S_GAP) begin
        if (addr == ADR_CHK) begin
          busy     <= 1'b0;
          sys_hold <= 1'b0;
          valid    <= 1'b1;
        end else begin
          addr <= addr + AW'(1);
        end
      end

      // Restart keeps the old type/size codes until the new scan overwrites them.
      if (state == S_DONE && reload) begin
        valid    <= 1'b0;
        busy     <= 1'b1;
        sys_hold <= 1'b1;
        chk      <= '0;
        size_err <= 1'b0;
        hdr_ok   <= 1'b0;
        addr     <= ADR_FIRST;
      end

      if (capture_c) begin
        if (addr < ADR_CHK) chk <= chk - rdata - 8'd1;
        if (addr == ADR_TYPE) mbc_type <= rdata;
        if (addr == ADR_ROM) begin
          rom_size <= (rdata > 8'd6) ? 3'd6 : rdata[2:0];
          if (rdata > 8'd6) size_err <= 1'b1;
        end
        if (addr == ADR_RAM) begin
          ram_size <= (rdata > 8'd3) ? 2'd3 : rdata[1:0];
          if (rdata > 8'd3) size_err <= 1'b1;
        end
        if (addr == ADR_CHK) hdr_ok <= (rdata == chk);
      end
    end
  end

endmodule

// File: tb/tb_cart_hdr_loader.sv
// Bench for cart_hdr_loader: ROM image model, header reference model, and a
// chip-select pulse monitor; one WAIT_CYCLES=1 and one WAIT_CYCLES=0 instance.
module tb_cart_hdr_loader;

  typedef logic [7:0] img_t [26];
  typedef struct packed {
    logic [7:0] mbc;
    logic [2:0] rom;
    logic [1:0] ram;
    logic       serr;
    logic       ok;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, reload1, reload0;
  img_t img1, img0;
  int   idx1, idx0;

  logic [7:0]  rdata1, rdata0, mbc1, mbc0;
  logic [14:0] oadr1, oadr0;
  logic        ocs1, ocs0, busy1, busy0, hold1, hold0, valid1, valid0;
  logic [2:0]  rom1, rom0;
  logic [1:0]  ram1, ram0;
  logic        serr1, serr0, ok1, ok0;

  int errors = 0;
  int checks = 0;

  always_comb begin
    idx1   = int'(oadr1) - 308;
    rdata1 = (idx1 >= 0 && idx1 < 26) ? img1[idx1] : 8'hFF;
  end
  always_comb begin
    idx0   = int'(oadr0) - 308;
    rdata0 = (idx0 >= 0 && idx0 < 26) ? img0[idx0] : 8'hFF;
  end

  cart_hdr_loader #(.WAIT_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .reload(reload1), .rdata(rdata1),
    .oadr(oadr1), .ocs_rom(ocs1), .busy(busy1), .sys_hold(hold1), .valid(valid1),
    .mbc_type(mbc1), .rom_size(rom1), .ram_size(ram1), .size_err(serr1), .hdr_ok(ok1));

  cart_hdr_loader #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .reload(reload0), .rdata(rdata0),
    .oadr(oadr0), .ocs_rom(ocs0), .busy(busy0), .sys_hold(hold0), .valid(valid0),
    .mbc_type(mbc0), .rom_size(rom0), .ram_size(ram0), .size_err(serr0), .hdr_ok(ok0));

  // Header checksum as a closed form: 0 - sum(b + 1) over 25 bytes, mod 256.
  function automatic logic [7:0] chk_of(input img_t im);
    int sum = 0;
    for (int i = 0; i < 25; i++) sum += int'(im[i]);
    return 8'(-(sum + 25));
  endfunction

  function automatic exp_t model(input img_t im);
    exp_t e;
    e.mbc  = im[19];
    e.rom  = (im[20] > 8'd6) ? 3'd6 : 3'(im[20]);
    e.ram  = (im[21] > 8'd3) ? 2'd3 : 2'(im[21]);
    e.serr = (im[20] > 8'd6) || (im[21] > 8'd3);
    e.ok   = (im[25] == chk_of(im));
    return e;
  endfunction

  // Chip-select monitor for dut1: pulse width, gap width, ascending addresses.
  bit mon_on = 0, mon_prev = 0, mon_first = 1;
  int mon_run = 0, mon_low = 0, mon_pulses = 0, mon_bad = 0;
  logic [14:0] mon_addr;

  always @(negedge clk) begin
    if (mon_on) begin
      if (ocs1) begin
        if (!mon_prev) begin
          if (!mon_first && mon_low != 1) mon_bad++;
          mon_first = 0;
          mon_run = 1;
        end else begin
          mon_run++;
        end
        if (oadr1 !== mon_addr) mon_bad++;
      end else begin
        if (mon_prev) begin
          mon_pulses++;
          if (mon_run != 2) mon_bad++;
          mon_addr = mon_addr + 15'd1;
          mon_low = 1;
        end else begin
          mon_low++;
        end
      end
      mon_prev = ocs1;
    end
  end

  task automatic mon_clear();
    mon_on = 1; mon_prev = 0; mon_first = 1;
    mon_run = 0; mon_low = 0; mon_pulses = 0; mon_bad = 0;
    mon_addr = 15'h0134;
  endtask

  task automatic fill(output img_t im, input logic [7:0] t, input logic [7:0] r,
                      input logic [7:0] m, input logic [7:0] c);
    for (int i = 0; i < 26; i++) im[i] = 8'h00;
    im[19] = t; im[20] = r; im[21] = m; im[25] = c;
  endtask

  task automatic do_reload();
    @(posedge clk); #1 reload1 = 1'b1;
    @(posedge clk); #1 reload1 = 1'b0;
    mon_clear();
  endtask

  // Cycles until valid; glitch_at > 0 injects an extra reload pulse mid-scan.
  task automatic wait_done(input int glitch_at, output int n);
    n = 0;
    while (!valid1 && n < 400) begin
      @(posedge clk); #1 n++;
      reload1 = (glitch_at > 0 && n == glitch_at);
    end
    reload1 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; reload1 = 1'b0; reload0 = 1'b0;
    fill(img1, 8'h00, 8'h00, 8'h00, 8'hE7);
    img0 = img1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ocs1, busy1, hold1, valid1} !== 4'b0110) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0110", {ocs1, busy1, hold1, valid1});
    end
    checks++;
    if ({mbc1, rom1, ram1, serr1, ok1} !== 15'd0) begin
      errors++; $display("FAIL reset_fields: got %h want 0", {mbc1, rom1, ram1, serr1, ok1});
    end
    checks++;
    if ({ocs0, busy0, hold0, valid0} !== 4'b0110) begin
      errors++; $display("FAIL reset_ctrl0: got %b want 0110", {ocs0, busy0, hold0, valid0});
    end
  endtask

  task automatic test_basic();
    int n = 0, n0 = 0;
    @(posedge clk); #1 reset = 1'b1;
    mon_clear();
    while (!valid1 && n < 400) begin
      @(posedge clk); #1 n++;
      if (valid0 && n0 == 0) n0 = n;
    end
    checks++;
    if (n !== 78) begin errors++; $display("FAIL basic_cycles: got %0d want 78", n); end
    checks++;
    if (n0 !== 52) begin errors++; $display("FAIL w0_cycles: got %0d want 52", n0); end
    checks++;
    if (mon_pulses !== 26 || mon_bad !== 0) begin
      errors++; $display("FAIL basic_pulses: got %0d pulses %0d bad want 26/0", mon_pulses, mon_bad);
    end
    checks++;
    if ({valid1, busy1, hold1} !== 3'b100) begin
      errors++; $display("FAIL basic_done_ctrl: got %b want 100", {valid1, busy1, hold1});
    end
    checks++;
    if ({mbc1, rom1, ram1, serr1, ok1} !== model(img1) || ok1 !== 1'b1) begin
      errors++; $display("FAIL basic_fields: got %h want %h", {mbc1, rom1, ram1, serr1, ok1}, model(img1));
    end
    checks++;
    if ({mbc0, rom0, ram0, serr0, ok0} !== model(img0)) begin
      errors++; $display("FAIL w0_fields: got %h want %h", {mbc0, rom0, ram0, serr0, ok0}, model(img0));
    end
  endtask

  task automatic run_image(input string name, input logic [7:0] t, input logic [7:0] r,
                           input logic [7:0] m, input logic [7:0] c, input exp_t want);
    int n;
    fill(img1, t, r, m, c);
    do_reload();
    wait_done(0, n);
    checks++;
    if (n !== 78 || valid1 !== 1'b1) begin
      errors++; $display("FAIL %s_cycles: got %0d valid %b want 78 valid 1", name, n, valid1);
    end
    checks++;
    if ({mbc1, rom1, ram1, serr1, ok1} !== want) begin
      errors++; $display("FAIL %s_fields: got %h want %h", name, {mbc1, rom1, ram1, serr1, ok1}, want);
    end
  endtask

  task automatic test_bad_chk();
    run_image("bad_chk", 8'h00, 8'h00, 8'h00, 8'hE6, '{8'h00, 3'd0, 2'd0, 1'b0, 1'b0});
  endtask

  task automatic test_fields();
    run_image("fields", 8'h03, 8'h05, 8'h03, 8'hDC, '{8'h03, 3'd5, 2'd3, 1'b0, 1'b1});
  endtask

  task automatic test_clamp();
    exp_t e;
    fill(img1, 8'h00, 8'h08, 8'h05, 8'h00);
    e = model(img1);
    run_image("clamp", 8'h00, 8'h08, 8'h05, 8'h00, '{8'h00, 3'd6, 2'd3, 1'b1, e.ok});
  endtask

  task automatic test_reset_mid();
    int n = 0;
    fill(img1, 8'h03, 8'h05, 8'h03, 8'hDC);
    do_reload();
    while (!(ocs1 && oadr1 == 15'h0140) && n < 200) begin @(posedge clk); #1 n++; end
    checks++;
    if (n >= 200) begin errors++; $display("FAIL mid_reach: got timeout want addr 0140"); end
    #2 reset = 1'b0;
    mon_on = 0;
    #1;
    checks++;
    if ({ocs1, busy1, hold1, valid1} !== 4'b0110) begin
      errors++; $display("FAIL mid_abort_ctrl: got %b want 0110", {ocs1, busy1, hold1, valid1});
    end
    checks++;
    if ({mbc1, rom1, ram1, serr1, ok1} !== 15'd0) begin
      errors++; $display("FAIL mid_abort_fields: got %h want 0", {mbc1, rom1, ram1, serr1, ok1});
    end
    @(posedge clk); #1 reset = 1'b1;
    mon_clear();
    wait_done(0, n);
    checks++;
    if (n !== 78 || mon_pulses !== 26 || mon_bad !== 0) begin
      errors++; $display("FAIL mid_rescan: got %0d cyc %0d pulses %0d bad want 78/26/0", n, mon_pulses, mon_bad);
    end
    checks++;
    if ({mbc1, rom1, ram1, serr1, ok1} !== model(img1)) begin
      errors++; $display("FAIL mid_fields: got %h want %h", {mbc1, rom1, ram1, serr1, ok1}, model(img1));
    end
  endtask

  task automatic test_reload();
    int n;
    fill(img1, 8'h1B, 8'h02, 8'h01, 8'h00);
    img1[25] = chk_of(img1);
    do_reload();
    checks++;
    if ({valid1, busy1, hold1} !== 3'b011) begin
      errors++; $display("FAIL reload_ctrl: got %b want 011", {valid1, busy1, hold1});
    end
    checks++;
    if ({mbc1, rom1, ram1, serr1, ok1} !== {8'h03, 3'd5, 2'd3, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reload_keep: got %h want %h", {mbc1, rom1, ram1, serr1, ok1},
                         {8'h03, 3'd5, 2'd3, 1'b0, 1'b0});
    end
    wait_done(20, n);
    checks++;
    if (n !== 78 || mon_pulses !== 26 || mon_bad !== 0) begin
      errors++; $display("FAIL reload_glitch: got %0d cyc %0d pulses %0d bad want 78/26/0", n, mon_pulses, mon_bad);
    end
    checks++;
    if ({mbc1, rom1, ram1, serr1, ok1} !== model(img1) || ok1 !== 1'b1) begin
      errors++; $display("FAIL reload_fields: got %h want %h", {mbc1, rom1, ram1, serr1, ok1}, model(img1));
    end
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 26; i++) img1[i] = 8'($urandom);
      img1[20] = 8'($urandom_range(0, 9));
      img1[21] = 8'($urandom_range(0, 5));
      if ($urandom_range(0, 1) == 1) img1[25] = chk_of(img1);
      do_reload();
      wait_done(0, n);
      checks++;
      if (n !== 78 || mon_pulses !== 26 || mon_bad !== 0) begin
        errors++; $display("FAIL rand%0d_scan: got %0d cyc %0d pulses %0d bad want 78/26/0", it, n, mon_pulses, mon_bad);
      end
      checks++;
      if ({mbc1, rom1, ram1, serr1, ok1} !== model(img1)) begin
        errors++; $display("FAIL rand%0d_fields: got %h want %h", it, {mbc1, rom1, ram1, serr1, ok1}, model(img1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_chk();
    test_fields();
    test_clamp();
    test_reset_mid();
    test_reload();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
